// File: rtl/alu_pkg.sv
// Shared definitions for the 12-bit registered ALU.
//   ALU_WIDTH : default operand/result width
//   op_e      : 3-bit operation codes driven on op_select
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 12;

  typedef enum logic [2:0] {
    OP_SHR = 3'd0,
    OP_SHL = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_ADD = 3'd6,
    OP_SUB = 3'd7
  } op_e;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor shared by the ALU's ADD and SUB operations.
//   a, b     : operands (two's complement for the overflow rule)
//   sub      : 1 selects a - b (computed as a + ~b + 1), 0 selects a + b
//   sum      : truncated WIDTH-bit result
//   carry    : carry out of the MSB (for SUB, 1 means no borrow)
//   overflow : signed overflow of the operation
module alu_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = full[WIDTH-1:0];
    carry = full[WIDTH];
    // Against the effective operand, the SUB rule (a, b differ in sign) is
    // the same test as ADD: operands agree in sign, result does not.
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_12bit.sv
// Registered ALU: combinational operation select, results and flags
// captured on every rising clock edge (1-cycle latency, no handshake).
//   clk, rst_n : clock, asynchronous active-low reset
//   a, b       : operands (b unused for SHR, SHL, NOT)
//   op_select  : operation code (see alu_pkg::op_e)
//   out        : registered result
//   zero, cout, sign, overflow : registered status flags
module alu_12bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op_select,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             cout,
  output logic             sign,
  output logic             overflow
);

  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;
  logic             as_sub;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  assign as_sub = (op_select == OP_SUB);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a        (a),
    .b        (b),
    .sub      (as_sub),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_select)
      OP_SHR: begin
        res   = {1'b0, a[WIDTH-1:1]};
        res_c = a[0];
      end
      OP_SHL: begin
        res   = {a[WIDTH-2:0], 1'b0};
        res_c = a[WIDTH-1];
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_ADD, OP_SUB: begin
        res   = as_sum;
        res_c = as_carry;
        res_v = as_ovf;
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      zero     <= 1'b0;
      cout     <= 1'b0;
      sign     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      out      <= res;
      zero     <= (res == '0);
      cout     <= res_c;
      sign     <= res[WIDTH-1];
      overflow <= res_v;
    end
  end

endmodule

// File: tb/tb_alu_12bit.sv
// Scoreboard bench for alu_12bit: directed vectors with hand-computed
// expectations are queued at issue; a monitor pops and compares one cycle later.
module tb_alu_12bit;

  localparam int unsigned W = 12;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op_select;
  logic [W-1:0] out;
  logic         zero;
  logic         cout;
  logic         sign;
  logic         overflow;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         zero;
    logic         cout;
    logic         sign;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  logic issue_vld;
  int   tests;
  int   fails;

  alu_12bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .op_select (op_select),
    .out       (out),
    .zero      (zero),
    .cout      (cout),
    .sign      (sign),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one operation at the falling edge and queue its expected response.
  task automatic issue(input string name, input logic [2:0] op,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] eo, input logic ec, input logic ev);
    exp_t e;
    @(negedge clk);
    a         = va;
    b         = vb;
    op_select = op;
    issue_vld = 1'b1;
    e.name = name;
    e.out  = eo;
    e.zero = (eo == '0);
    e.cout = ec;
    e.sign = eo[W-1];
    e.ovf  = ev;
    sb_q.push_back(e);
  endtask

  // Monitor: an operation valid at a rising edge is visible just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (issue_vld) begin
        #1;
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_underflow: got out=%h with no expected entry", out);
        end else begin
          e = sb_q.pop_front();
          if (out !== e.out || zero !== e.zero || cout !== e.cout ||
              sign !== e.sign || overflow !== e.ovf) begin
            fails++;
            $display("FAIL %s: got out=%h z=%b c=%b s=%b v=%b, expected out=%h z=%b c=%b s=%b v=%b",
                     e.name, out, zero, cout, sign, overflow,
                     e.out, e.zero, e.cout, e.sign, e.ovf);
          end
        end
      end
    end
  end

  task automatic check_reset(input string name);
    tests++;
    if (out !== '0 || zero !== 1'b0 || cout !== 1'b0 || sign !== 1'b0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL %s: got out=%h z=%b c=%b s=%b v=%b, expected all zero",
               name, out, zero, cout, sign, overflow);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests     = 0;
    fails     = 0;
    issue_vld = 1'b0;
    a         = '0;
    b         = '0;
    op_select = 3'd0;
    rst_n     = 1'b0;
    #12;
    check_reset("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    //     name              op  a       b       out     cout  ovf
    issue("add_neg_ovf",    6, 12'h801, 12'h861, 12'h062, 1'b1, 1'b1);
    issue("add_no_ovf",     6, 12'h60F, 12'h061, 12'h670, 1'b0, 1'b0);
    issue("add_pos_ovf",    6, 12'h69F, 12'h769, 12'hE08, 1'b0, 1'b1);
    issue("add_wrap_zero",  6, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b0);
    issue("sub_ovf",        7, 12'h815, 12'h76B, 12'h0AA, 1'b1, 1'b1);
    issue("sub_zero",       7, 12'h123, 12'h123, 12'h000, 1'b1, 1'b0);
    issue("sub_borrow",     7, 12'h000, 12'h001, 12'hFFF, 1'b0, 1'b0);
    issue("sub_min_ovf",    7, 12'h800, 12'h001, 12'h7FF, 1'b1, 1'b1);
    issue("shr",            0, 12'hEF1, 12'hE65, 12'h778, 1'b1, 1'b0);
    issue("shl",            1, 12'hEF1, 12'hE65, 12'hDE2, 1'b1, 1'b0);
    issue("and",            2, 12'hEF1, 12'hE65, 12'hE61, 1'b0, 1'b0);
    issue("or",             3, 12'hEF1, 12'hE65, 12'hEF5, 1'b0, 1'b0);
    issue("xor",            4, 12'hEF1, 12'hE65, 12'h094, 1'b0, 1'b0);
    issue("not",            5, 12'hEF1, 12'hE65, 12'h10E, 1'b0, 1'b0);
    issue("shr_to_zero",    0, 12'h001, 12'hFFF, 12'h000, 1'b1, 1'b0);
    issue("shl_msb_out",    1, 12'h800, 12'h000, 12'h000, 1'b1, 1'b0);
    issue("not_all_ones",   5, 12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0);
    issue("xor_self_zero",  4, 12'hA5A, 12'hA5A, 12'h000, 1'b0, 1'b0);
    issue("add_prime",      6, 12'h0F0, 12'h810, 12'h900, 1'b0, 1'b0);

    @(negedge clk);
    issue_vld = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    // Mid-cycle asynchronous reset with nonzero outputs held (0x900, sign=1).
    tests++;
    if (out !== 12'h900) begin
      fails++;
      $display("FAIL pre_reset_hold: got out=%h, expected 900", out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async_midcycle");
    @(negedge clk);
    rst_n = 1'b1;

    issue("post_reset_add", 6, 12'h001, 12'h002, 12'h003, 1'b0, 1'b0);
    @(negedge clk);
    issue_vld = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
